// File: rtl/dac_stream_ctrl.sv
// dac_stream_ctrl: streams fetched blocks into a double-buffered DAC, one buffer half per block.
// Optional DAC_UNDERRUN_MUTE_EN mutes playback while a late (underrun) fill is still in progress.
module dac_stream_ctrl #(
    parameter int HALF_BYTES = 1024
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        repeat_en,
    input  logic [15:0] track_len,
    input  logic [15:0] loop_blk,
    output logic        mem_req,
    output logic [15:0] mem_blk,
    input  logic        mem_ack,
    input  logic        mem_valid,
    input  logic [7:0]  mem_data,
    output logic        dac_we,
    output logic [10:0] dac_addr,
    output logic [7:0]  dac_data,
    input  logic        dac_status,
    output logic        dac_play,
    output logic        dac_reset,
    output logic        busy,
    output logic        underrun
);
    typedef enum logic [2:0] {IDLE, PRIME0, PRIME1, KICK, RUN, FILL, SILENCE, DRAIN} state_t;
    localparam logic [9:0] LAST = 10'(HALF_BYTES - 1);

    state_t      r_state, w_next;
    logic [15:0] r_len, r_loop, r_blk;
    logic [9:0]  r_off;
    logic [10:0] r_addr;
    logic [7:0]  r_data;
    logic        r_half, r_end, r_sdone, r_req, r_got, r_st, r_pend, r_ph, r_play, r_under, r_we;
    logic        w_fst, w_sil, w_acc, w_done, w_edge, w_svc, w_late, w_go;

    always_comb begin
        w_fst  = r_state inside {PRIME0, PRIME1, FILL, SILENCE};
        w_sil  = r_state == SILENCE || (r_state inside {PRIME0, PRIME1} && r_end);
        w_acc  = w_fst && !stop && (w_sil || (r_got && mem_valid));
        w_done = w_acc && r_off == LAST;
        w_edge = dac_status != r_st;
        w_svc  = r_state == RUN && (w_edge || r_pend);
        w_late = r_state inside {FILL, SILENCE} && w_edge;
        w_go   = r_state == IDLE && start && !stop;
    end

    always_ff @(posedge clkin or posedge reset)
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:          w_next = w_go ? PRIME0 : IDLE;
            PRIME0:        w_next = w_done ? PRIME1 : PRIME0;
            PRIME1:        w_next = w_done ? KICK : PRIME1;
            KICK:          w_next = RUN;
            RUN:           w_next = !w_svc ? RUN : r_sdone ? DRAIN : r_end ? SILENCE : FILL;
            FILL, SILENCE: w_next = w_done ? RUN : r_state;
            DRAIN:         w_next = w_edge ? IDLE : DRAIN;
            default:       w_next = IDLE;
        endcase
        if (stop) w_next = IDLE;
    end

    always_comb begin
        dac_reset = r_state == KICK;
        busy      = r_state != IDLE;
    end

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_len   <= '0;
            r_loop  <= '0;
            r_blk   <= '0;
            r_off   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_half  <= 1'b0;
            r_end   <= 1'b0;
            r_sdone <= 1'b0;
            r_req   <= 1'b0;
            r_got   <= 1'b0;
            r_st    <= 1'b0;
            r_pend  <= 1'b0;
            r_ph    <= 1'b0;
            r_play  <= 1'b0;
            r_under <= 1'b0;
            r_we    <= 1'b1;
        end else begin
            r_we <= !w_acc;
            if (w_acc) begin
                r_addr <= {r_half, r_off};
                r_data <= w_sil ? 8'h00 : mem_data;
                r_off  <= w_done ? 10'd0 : r_off + 10'd1;
            end
            if (w_fst && !w_sil && !r_got && !r_req && !stop) r_req <= 1'b1;
            if (r_req && mem_ack) begin
                r_req <= 1'b0;
                r_got <= 1'b1;
            end
            if (w_done) begin
                r_got  <= 1'b0;
                r_half <= !r_half;
                if (w_sil) r_sdone <= 1'b1;
                else if (r_blk + 16'd1 == r_len) begin
                    if (repeat_en) r_blk <= r_loop;
                    else           r_end <= 1'b1;
                end else r_blk <= r_blk + 16'd1;
            end
            r_st <= dac_status;
            // an edge arriving mid-fill is remembered and serviced once the fill lands
            if (w_late) begin
                r_under <= 1'b1;
                r_pend  <= 1'b1;
                r_ph    <= r_st;
            end
            if (w_svc) begin
                r_half <= w_edge ? r_st : r_ph;
                r_pend <= 1'b0;
            end
            if (r_state == KICK) r_play <= 1'b1;
            if (r_state == DRAIN && w_edge) r_play <= 1'b0;
            if (w_go) begin
                r_len   <= track_len;
                r_loop  <= loop_blk;
                r_blk   <= '0;
                r_end   <= track_len == 16'd0;
                r_sdone <= 1'b0;
                r_under <= 1'b0;
                r_half  <= 1'b0;
                r_off   <= '0;
                r_pend  <= 1'b0;
            end
            if (stop) begin
                r_req  <= 1'b0;
                r_got  <= 1'b0;
                r_play <= 1'b0;
                r_off  <= '0;
                r_pend <= 1'b0;
            end
        end
    end

    assign mem_req  = r_req;
    assign mem_blk  = r_blk;
    assign dac_we   = r_we;
    assign dac_addr = r_addr;
    assign dac_data = r_data;
    assign underrun = r_under;

`ifdef DAC_UNDERRUN_MUTE_EN
    logic r_mute;
    always_ff @(posedge clkin or posedge reset)
        if (reset)                      r_mute <= 1'b0;
        else if (w_done || stop || w_go) r_mute <= 1'b0;
        else if (w_late)                r_mute <= 1'b1;
    assign dac_play = r_play && !r_mute;
`else
    assign dac_play = r_play;
`endif
endmodule

// File: tb/tb_dac_stream_ctrl.sv
// tb_dac_stream_ctrl: directed scenarios for dac_stream_ctrl with a byte-source model and DAC buffer image.
// Honours DAC_UNDERRUN_MUTE_EN when checking dac_play during an underrun.
module tb_dac_stream_ctrl;
    localparam int HALF = 1024;

    logic        clkin = 1'b0;
    logic        reset, start, stop, repeat_en, dac_status;
    logic [15:0] track_len, loop_blk, mem_blk;
    logic        mem_req, mem_ack, mem_valid;
    logic [7:0]  mem_data, dac_data;
    logic        dac_we, dac_play, dac_reset, busy, underrun;
    logic [10:0] dac_addr;

    logic [7:0]  img [0:2047];
    int          wcnt = 0, req_cyc = 0, src_cnt = 0, src_blk = 0;
    int          blk_log[$];
    int          errors = 0, checks = 0;

    dac_stream_ctrl #(.HALF_BYTES(HALF)) dut (
        .clkin(clkin), .reset(reset), .start(start), .stop(stop), .repeat_en(repeat_en),
        .track_len(track_len), .loop_blk(loop_blk), .mem_req(mem_req), .mem_blk(mem_blk),
        .mem_ack(mem_ack), .mem_valid(mem_valid), .mem_data(mem_data), .dac_we(dac_we),
        .dac_addr(dac_addr), .dac_data(dac_data), .dac_status(dac_status), .dac_play(dac_play),
        .dac_reset(dac_reset), .busy(busy), .underrun(underrun)
    );

    always #5 clkin = ~clkin;

    function automatic logic [7:0] f(input int b, input int o);
        f = 8'(b * 37 + o * 3 + 1);
    endfunction

    // byte source: one-cycle ack, then HALF consecutive bytes of the acked block
    initial begin
        mem_ack = 1'b0; mem_valid = 1'b0; mem_data = 8'h00;
        forever begin
            @(posedge clkin); #1;
            mem_valid = 1'b0;
            if (mem_ack) begin
                mem_ack = 1'b0;
                src_cnt = HALF;
            end else if (src_cnt == 0 && mem_req === 1'b1) begin
                mem_ack = 1'b1;
                src_blk = int'(mem_blk);
                blk_log.push_back(src_blk);
            end
            if (src_cnt > 0) begin
                mem_valid = 1'b1;
                mem_data  = f(src_blk, HALF - src_cnt);
                src_cnt--;
            end
        end
    end

    always @(posedge clkin) begin
        #2;
        if (dac_we === 1'b0) begin
            img[dac_addr] = dac_data;
            wcnt++;
        end
        if (mem_req === 1'b1) req_cyc++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit hit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic pulse_start();
        start = 1'b1; @(negedge clkin); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; @(negedge clkin); stop = 1'b0;
    endtask

    task automatic src_abort();
        src_cnt = 0; mem_ack = 1'b0; mem_valid = 1'b0;
    endtask

    task automatic wait_kick(output bit ok);
        for (int i = 0; i < 3000 && dac_reset !== 1'b1; i++) @(negedge clkin);
        ok = dac_reset === 1'b1;
    endtask

    task automatic wait_wr(input logic [10:0] a, input int lim, output bit ok);
        for (int i = 0; i < lim && !(dac_we === 1'b0 && dac_addr === a); i++) @(negedge clkin);
        ok = dac_we === 1'b0 && dac_addr === a;
    endtask

    task automatic wait_writes(input int n, output bit ok);
        int target;
        target = wcnt + n;
        for (int i = 0; i < 3000 && wcnt < target; i++) @(negedge clkin);
        ok = wcnt >= target;
    endtask

    task automatic wait_req(output bit ok);
        for (int i = 0; i < 20 && mem_req !== 1'b1; i++) @(negedge clkin);
        ok = mem_req === 1'b1;
    endtask

    task automatic test_reset();
        logic [40:0] obs, exp;
        reset = 1'b1; start = 1'b0; stop = 1'b0; repeat_en = 1'b0; dac_status = 1'b0;
        track_len = '0; loop_blk = '0;
        for (int i = 0; i < 2048; i++) img[i] = 8'h00;
        tick(3);
        obs = {mem_req, mem_blk, dac_we, dac_addr, dac_data, dac_play, dac_reset, busy, underrun};
        exp = {1'b0, 16'h0, 1'b1, 11'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, exp); end
        reset = 1'b0;
        tick(3);
        checks++;
        if (busy !== 1'b0 || dac_we !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: busy=%b we=%b req=%b want 0 1 0", busy, dac_we, mem_req);
        end
    endtask

    task automatic test_play_once();
        bit ok;
        int base, rq;
        dac_status = 1'b0; track_len = 16'd3; loop_blk = 16'd0; repeat_en = 1'b0;
        base = wcnt;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
        wait_wr(11'h3FF, 1500, ok);
        checks++;
        if (!ok || dac_data !== f(0, 1023)) begin
            errors++; $display("FAIL byte1023: seen=%b data=%h want addr 3ff data %h", ok, dac_data, f(0, 1023));
        end
        @(negedge clkin);
        for (int i = 0; i < 20 && dac_we !== 1'b0; i++) @(negedge clkin);
        checks++;
        if (dac_we !== 1'b0 || dac_addr !== 11'h400 || dac_data !== f(1, 0)) begin
            errors++; $display("FAIL next_block_offset0: we=%b addr=%h data=%h want 0 400 %h", dac_we, dac_addr, dac_data, f(1, 0));
        end
        wait_kick(ok);
        checks++;
        if (!ok || dac_play !== 1'b0 || wcnt - base != 2048 || img[11'h7FF] !== f(1, 1023)) begin
            errors++; $display("FAIL prime_kick: kick=%b play=%b writes=%0d last=%h want 1 0 2048 %h", ok, dac_play, wcnt - base, img[11'h7FF], f(1, 1023));
        end
        @(negedge clkin);
        checks++;
        if (dac_play !== 1'b1 || dac_reset !== 1'b0) begin
            errors++; $display("FAIL play_after_kick: play=%b dreset=%b want 1 0", dac_play, dac_reset);
        end
        dac_status = 1'b1;
        wait_req(ok);
        checks++;
        if (!ok || mem_blk !== 16'd2) begin errors++; $display("FAIL fill_blk: req=%b blk=%0d want 1 2", ok, mem_blk); end
        wait_writes(HALF, ok);
        checks++;
        if (!ok || img[11'h000] !== f(2, 0) || img[11'h3FF] !== f(2, 1023)) begin
            errors++; $display("FAIL fill_half0: done=%b d0=%h d3ff=%h want 1 %h %h", ok, img[11'h000], img[11'h3FF], f(2, 0), f(2, 1023));
        end
        tick(5);
        rq = req_cyc;
        dac_status = 1'b0;
        wait_writes(HALF, ok);
        checks++;
        if (!ok || req_cyc != rq || img[11'h400] !== 8'h00 || img[11'h7FF] !== 8'h00) begin
            errors++; $display("FAIL silence_half1: done=%b reqcyc=%0d d400=%h d7ff=%h want 1 0 00 00", ok, req_cyc - rq, img[11'h400], img[11'h7FF]);
        end
        tick(5);
        dac_status = 1'b1;
        tick(5);
        checks++;
        if (dac_play !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL drain_hold: play=%b busy=%b want 1 1", dac_play, busy);
        end
        dac_status = 1'b0;
        @(negedge clkin);
        checks++;
        if (dac_play !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
            errors++; $display("FAIL drain_end: play=%b busy=%b under=%b want 0 0 0", dac_play, busy, underrun);
        end
    endtask

    task automatic test_repeat();
        bit ok;
        int nok;
        int exp_blk[7] = '{0, 1, 2, 3, 2, 3, 2};
        dac_status = 1'b0; track_len = 16'd4; loop_blk = 16'd2; repeat_en = 1'b1;
        blk_log.delete();
        nok = 0;
        pulse_start();
        wait_kick(ok);
        if (!ok) nok++;
        @(negedge clkin);
        track_len = 16'd1;
        pulse_start();
        track_len = 16'd4;
        for (int k = 0; k < 5; k++) begin
            dac_status = !dac_status;
            wait_writes(HALF, ok);
            if (!ok) nok++;
        end
        tick(2);
        checks++;
        if (nok != 0) begin errors++; $display("FAIL repeat_progress: stalled=%0d want 0", nok); end
        checks++;
        if (blk_log.size() != 7) begin errors++; $display("FAIL repeat_count: got %0d want 7", blk_log.size()); end
        for (int i = 0; i < 7 && i < blk_log.size(); i++) begin
            checks++;
            if (blk_log[i] != exp_blk[i]) begin errors++; $display("FAIL repeat_blk[%0d]: got %0d want %0d", i, blk_log[i], exp_blk[i]); end
        end
        checks++;
        if (dac_play !== 1'b1 || underrun !== 1'b0) begin
            errors++; $display("FAIL repeat_play: play=%b under=%b want 1 0", dac_play, underrun);
        end
        pulse_stop();
        src_abort();
        tick(2);
    endtask

    task automatic test_underrun();
        bit ok;
        logic exp_play;
        dac_status = 1'b0; track_len = 16'd8; loop_blk = 16'd0; repeat_en = 1'b0;
        pulse_start();
        wait_kick(ok);
        @(negedge clkin);
        dac_status = 1'b1;
        wait_writes(100, ok);
        dac_status = 1'b0;
        @(negedge clkin);
`ifdef DAC_UNDERRUN_MUTE_EN
        exp_play = 1'b0;
`else
        exp_play = 1'b1;
`endif
        checks++;
        if (underrun !== 1'b1 || dac_play !== exp_play) begin
            errors++; $display("FAIL underrun_flag: under=%b play=%b want 1 %b", underrun, dac_play, exp_play);
        end
        tick(50);
        dac_status = 1'b1;
        wait_wr(11'h3FF, 1200, ok);
        checks++;
        if (!ok || dac_data !== f(2, 1023)) begin
            errors++; $display("FAIL underrun_orig_half: seen=%b data=%h want 1 %h", ok, dac_data, f(2, 1023));
        end
        checks++;
        if (img[11'h400] !== f(1, 0) || img[11'h7FF] !== f(1, 1023)) begin
            errors++; $display("FAIL underrun_other_half: d400=%h d7ff=%h want %h %h", img[11'h400], img[11'h7FF], f(1, 0), f(1, 1023));
        end
        checks++;
        if (dac_play !== 1'b1 || underrun !== 1'b1) begin
            errors++; $display("FAIL underrun_after_fill: play=%b under=%b want 1 1", dac_play, underrun);
        end
        pulse_stop();
        src_abort();
        tick(2);
    endtask

    task automatic test_stop();
        bit ok;
        int w0, rq;
        dac_status = 1'b0; track_len = 16'd4; loop_blk = 16'd0; repeat_en = 1'b0;
        pulse_start();
        wait_wr(11'h5F4, 2500, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stop_reach_byte500: seen=%b want 1", ok); end
        pulse_stop();
        checks++;
        if (busy !== 1'b0 || dac_play !== 1'b0 || mem_req !== 1'b0 || dac_we !== 1'b1) begin
            errors++; $display("FAIL stop_outputs: busy=%b play=%b req=%b we=%b want 0 0 0 1", busy, dac_play, mem_req, dac_we);
        end
        w0 = wcnt; rq = req_cyc;
        tick(20);
        checks++;
        if (wcnt != w0 || req_cyc != rq) begin
            errors++; $display("FAIL stop_quiet: writes=%0d reqcyc=%0d want 0 0", wcnt - w0, req_cyc - rq);
        end
        src_abort();
        start = 1'b1; stop = 1'b1;
        @(negedge clkin);
        start = 1'b0; stop = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b0 || req_cyc != rq) begin
            errors++; $display("FAIL stop_beats_start: busy=%b reqcyc=%0d want 0 0", busy, req_cyc - rq);
        end
    endtask

    task automatic test_reset_fill();
        bit ok;
        int w0, rq;
        logic [40:0] obs, exp;
        dac_status = 1'b0; track_len = 16'd4; loop_blk = 16'd0; repeat_en = 1'b0;
        pulse_start();
        wait_kick(ok);
        @(negedge clkin);
        dac_status = 1'b1;
        wait_writes(100, ok);
        reset = 1'b1;
        #1;
        obs = {mem_req, mem_blk, dac_we, dac_addr, dac_data, dac_play, dac_reset, busy, underrun};
        exp = {1'b0, 16'h0, 1'b1, 11'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL reset_mid_fill: got %h want %h", obs, exp); end
        @(negedge clkin);
        reset = 1'b0;
        src_abort();
        w0 = wcnt; rq = req_cyc;
        tick(20);
        checks++;
        if (wcnt != w0 || req_cyc != rq) begin
            errors++; $display("FAIL reset_quiet: writes=%0d reqcyc=%0d want 0 0", wcnt - w0, req_cyc - rq);
        end
        pulse_start();
        wait_req(ok);
        checks++;
        if (!ok || mem_blk !== 16'd0) begin errors++; $display("FAIL restart_blk: req=%b blk=%0d want 1 0", ok, mem_blk); end
        for (int i = 0; i < 20 && dac_we !== 1'b0; i++) @(negedge clkin);
        checks++;
        if (dac_we !== 1'b0 || dac_addr !== 11'h000 || dac_data !== f(0, 0)) begin
            errors++; $display("FAIL restart_first_byte: we=%b addr=%h data=%h want 0 000 %h", dac_we, dac_addr, dac_data, f(0, 0));
        end
        pulse_stop();
        src_abort();
        tick(2);
    endtask

    task automatic test_len0();
        bit ok;
        int rq;
        dac_status = 1'b0; track_len = 16'd0; loop_blk = 16'd0; repeat_en = 1'b0;
        rq = req_cyc;
        pulse_start();
        wait_kick(ok);
        checks++;
        if (!ok || req_cyc != rq) begin errors++; $display("FAIL len0_no_fetch: kick=%b reqcyc=%0d want 1 0", ok, req_cyc - rq); end
        checks++;
        if (img[11'h000] !== 8'h00 || img[11'h3FF] !== 8'h00 || img[11'h7FF] !== 8'h00) begin
            errors++; $display("FAIL len0_silence: d0=%h d3ff=%h d7ff=%h want 00 00 00", img[11'h000], img[11'h3FF], img[11'h7FF]);
        end
        tick(2);
        dac_status = 1'b1;
        tick(3);
        checks++;
        if (dac_play !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL len0_drain: play=%b busy=%b want 1 1", dac_play, busy); end
        dac_status = 1'b0;
        @(negedge clkin);
        checks++;
        if (dac_play !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL len0_end: play=%b busy=%b want 0 0", dac_play, busy); end
    endtask

    initial begin
        test_reset();
        test_play_once();
        test_repeat();
        test_underrun();
        test_stop();
        test_reset_fill();
        test_len0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dac_stream_ctrl.md
DAC_STREAM_CTRL -- requirements
Module: dac_stream_ctrl

Interface
REQ-001 SHALL have parameter HALF_BYTES, default 1024: bytes per DAC buffer half; dac_addr bit 10 selects the half.
REQ-002 SHALL have port clkin, in, 1: sole clock; all logic on rising edge.
REQ-003 SHALL have port reset, in, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port start, in, 1: one-cycle pulse, begin stream at block 0.
REQ-005 SHALL have port stop, in, 1: one-cycle pulse, abort stream.
REQ-006 SHALL have port repeat_en, in, 1: loop at end of track.
REQ-007 SHALL have port track_len, in, 16: track length in blocks (1 block = HALF_BYTES bytes), sampled on start.
REQ-008 SHALL have port loop_blk, in, 16: loop target block, sampled on start.
REQ-009 SHALL have ports mem_req out 1, mem_blk out 16, mem_ack in 1, mem_valid in 1, mem_data in 8: block fetch from the byte source.
REQ-010 SHALL have ports dac_we out 1 (active-low write strobe), dac_addr out 11, dac_data out 8: DAC buffer write port.
REQ-011 SHALL have ports dac_status in 1 (DAC half-in-play bit), dac_play out 1, dac_reset out 1 (DAC address reset).
REQ-012 SHALL have ports busy out 1 (state != IDLE) and underrun out 1 (sticky).

Function
REQ-013 SHALL implement states IDLE, PRIME0, PRIME1, KICK, RUN, FILL, SILENCE, DRAIN.
REQ-014 IDLE + start: latch track_len/loop_blk, blk=0, clear underrun, go PRIME0; start ignored when not IDLE.
REQ-015 Block fetch: assert mem_req with mem_blk=blk until mem_ack (held stable until acked); then accept exactly HALF_BYTES mem_valid bytes.
REQ-016 Each mem_valid byte: next cycle dac_we=0 for one cycle, dac_data=byte, dac_addr={half, offset}; offset increments 0..HALF_BYTES-1 and wraps to 0 at block end; dac_we=1 otherwise.
REQ-017 PRIME0 fills half 0, PRIME1 fills half 1; then KICK: dac_reset=1 one cycle, dac_play=1 from next cycle, go RUN.
REQ-018 RUN: register dac_status; on 0->1 edge fill half 0, on 1->0 edge fill half 1 (FILL).
REQ-019 After each completed block: blk+1; if blk+1==track_len then blk=loop_blk when repeat_en, else end_flag=1.
REQ-020 FILL with end_flag set SHALL enter SILENCE instead: write HALF_BYTES bytes of 0x00, one per cycle, no mem_req.
REQ-021 After a silence half is written, next dac_status edge -> DRAIN; DRAIN waits for the following edge (silence half reached), then dac_play=0, go IDLE.
REQ-022 A dac_status edge during FILL/SILENCE SHALL set underrun=1; the fill completes into its original half; the pending edge is then serviced.
REQ-023 stop in any state: dac_play=0, mem_req=0, dac_we=1, go IDLE next cycle; in-flight mem_valid bytes ignored.
REQ-024 track_len==0 SHALL be treated as end at block 0: both primes are silence.
REQ-025 stop and start same cycle: stop wins.

Reset
REQ-026 reset SHALL force IDLE, blk=0, offset=0, end_flag=0, mem_req=0, mem_blk=0, dac_we=1, dac_addr=0, dac_data=0, dac_play=0, dac_reset=0, busy=0, underrun=0.
REQ-027 Reset mid-fill SHALL abandon the block; no further dac_we pulses.

Configuration
REQ-028 Macro DAC_UNDERRUN_MUTE_EN defined: on underrun dac_play=0 until the in-progress fill completes, then 1 again.
REQ-029 Macro DAC_UNDERRUN_MUTE_EN undefined: dac_play unaffected by underrun; only the underrun flag is set.

Verification
REQ-030 track_len=3, repeat_en=0, start; source answers every byte -> blocks 0,1 primed, dac_reset pulse, block 2 after first edge, silence fill, dac_play=0 two edges later.
REQ-031 track_len=4, loop_blk=2, repeat_en=1 -> mem_blk sequence 0,1,2,3,2,3,2...; dac_play stays 1.
REQ-032 Byte 1023 of a half-0 fill -> dac_addr=0x3FF, dac_we=0; next block starts at offset 0.
REQ-033 dac_status toggles twice during one FILL -> underrun=1, write completes into original half; with DAC_UNDERRUN_MUTE_EN, dac_play=0 during the fill.
REQ-034 stop during PRIME1 at byte 500 -> IDLE next cycle, dac_we stays 1, mem_req=0.
REQ-035 reset during FILL -> all outputs at reset values; start then primes from block 0.
